// File: rtl/tri_mem_arbiter.sv
// Arbitrates the shared triangle SRAM between N_REQ round-robin read streamers
// and one priority scene loader, returning read data tagged with a one-hot valid.
module tri_mem_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned A_BITS    = 12,
  parameter int unsigned D_BITS    = 32,
  parameter int unsigned TRI_WORDS = 12,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned LD_BURST  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_REQ-1:0]              rd_req_i,
  input  logic [N_REQ*A_BITS-1:0]       rd_addr_i,
  output logic [N_REQ-1:0]              rd_gnt_o,
  output logic [N_REQ-1:0]              rd_valid_o,
  output logic [TRI_WORDS*D_BITS-1:0]   rd_data_o,
  input  logic                          ld_req_i,
  input  logic [A_BITS-1:0]             ld_addr_i,
  input  logic [TRI_WORDS*D_BITS-1:0]   ld_data_i,
  output logic                          ld_gnt_o,
  output logic                          mem_rd_en_o,
  output logic [A_BITS-1:0]             mem_rd_addr_o,
  output logic                          mem_wr_en_o,
  output logic [A_BITS-1:0]             mem_wr_addr_o,
  output logic [TRI_WORDS*D_BITS-1:0]   mem_din_o,
  input  logic [TRI_WORDS*D_BITS-1:0]   mem_dout_i
);

  localparam int unsigned REC_W    = TRI_WORDS * D_BITS;
  localparam int unsigned PTR_W    = $clog2(N_REQ);
  localparam int unsigned STREAK_W = $clog2(LD_BURST + 1);
  localparam int unsigned TAG_D    = MEM_LAT + 1;

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [STREAK_W-1:0] ld_streak_q, ld_streak_d;
  logic [N_REQ-1:0]    tag_q [TAG_D];

  logic                mem_rd_en_q, mem_wr_en_q;
  logic [A_BITS-1:0]   mem_rd_addr_q, mem_wr_addr_q;
  logic [REC_W-1:0]    mem_din_q;

  logic                ld_gnt_c;
  logic [N_REQ-1:0]    rd_gnt_c;
  logic                rd_found;
  logic [PTR_W-1:0]    gnt_idx;
  int unsigned         idx;
  logic                ld_blocked;

  // Loader wins unless it has used its full burst while a read waits.
  assign ld_blocked = (ld_streak_q == STREAK_W'(LD_BURST)) && (|rd_req_i);

  always_comb begin
    ld_gnt_c = 1'b0;
    rd_gnt_c = '0;
    rd_found = 1'b0;
    gnt_idx  = '0;
    idx      = 0;
    if (rst_ni) begin
      if (ld_req_i && !ld_blocked) begin
        ld_gnt_c = 1'b1;
      end else begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
          idx = int'(rr_ptr_q) + i;
          if (idx >= N_REQ) idx = idx - N_REQ;
          if (!rd_found && rd_req_i[PTR_W'(idx)]) begin
            rd_found = 1'b1;
            gnt_idx  = PTR_W'(idx);
          end
        end
        if (rd_found) rd_gnt_c[gnt_idx] = 1'b1;
      end
    end
  end

  // Pointer advances past the winner; streak counts loader grants while ld_req stays up.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    ld_streak_d = ld_streak_q;
    if (!ld_req_i) ld_streak_d = '0;
    if (ld_gnt_c) begin
      if (ld_streak_q != STREAK_W'(LD_BURST)) ld_streak_d = ld_streak_q + STREAK_W'(1);
    end else if (rd_found) begin
      rr_ptr_d    = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      ld_streak_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q      <= '0;
      ld_streak_q   <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_wr_addr_q <= '0;
      mem_din_q     <= '0;
      for (int unsigned i = 0; i < TAG_D; i++) tag_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      ld_streak_q <= ld_streak_d;
      mem_rd_en_q <= rd_found;
      mem_wr_en_q <= ld_gnt_c;
      if (rd_found) mem_rd_addr_q <= rd_addr_i[A_BITS*gnt_idx +: A_BITS];
      if (ld_gnt_c) begin
        mem_wr_addr_q <= ld_addr_i;
        mem_din_q     <= ld_data_i;
      end
      // Tag pipeline lines the grant up with the SRAM read latency.
      tag_q[0] <= rd_gnt_c;
      for (int unsigned i = 1; i < TAG_D; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rd_gnt_o      = rd_gnt_c;
  assign ld_gnt_o      = ld_gnt_c;
  assign rd_valid_o    = tag_q[MEM_LAT];
  assign rd_data_o     = mem_dout_i;
  assign mem_rd_en_o   = mem_rd_en_q;
  assign mem_rd_addr_o = mem_rd_addr_q;
  assign mem_wr_en_o   = mem_wr_en_q;
  assign mem_wr_addr_o = mem_wr_addr_q;
  assign mem_din_o     = mem_din_q;

endmodule

// File: tb/tb_tri_mem_arbiter.sv
// Directed bench for tri_mem_arbiter with a 1-cycle-latency SRAM model.
module tb_tri_mem_arbiter;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned A_BITS    = 12;
  localparam int unsigned D_BITS    = 32;
  localparam int unsigned TRI_WORDS = 12;
  localparam int unsigned REC_W     = TRI_WORDS * D_BITS;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic [N_REQ-1:0]          rd_req;
  logic [N_REQ*A_BITS-1:0]   rd_addr;
  logic [N_REQ-1:0]          rd_gnt, rd_valid;
  logic [REC_W-1:0]          rd_data;
  logic                      ld_req;
  logic [A_BITS-1:0]         ld_addr;
  logic [REC_W-1:0]          ld_data;
  logic                      ld_gnt;
  logic                      mem_rd_en, mem_wr_en;
  logic [A_BITS-1:0]         mem_rd_addr, mem_wr_addr;
  logic [REC_W-1:0]          mem_din, mem_dout;

  logic [REC_W-1:0]          sram [4096];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  tri_mem_arbiter #(
    .N_REQ(N_REQ), .A_BITS(A_BITS), .D_BITS(D_BITS), .TRI_WORDS(TRI_WORDS),
    .MEM_LAT(1), .LD_BURST(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_gnt_o(ld_gnt),
    .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr),
    .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr),
    .mem_din_o(mem_din), .mem_dout_i(mem_dout)
  );

  // Registered-output SRAM: read sampled on one edge is visible after it.
  always @(posedge clk_i) begin
    if (mem_wr_en) sram[mem_wr_addr] <= mem_din;
    if (mem_rd_en) mem_dout <= sram[mem_rd_addr];
  end

  function automatic logic [REC_W-1:0] rec(input logic [A_BITS-1:0] a);
    logic [REC_W-1:0] r;
    for (int w = 0; w < TRI_WORDS; w++) r[w*D_BITS +: D_BITS] = {4'h0, a, 16'(w)};
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [REC_W-1:0] got,
                          input logic [REC_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [A_BITS-1:0] a);
    rd_addr[k*A_BITS +: A_BITS] = a;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [REC_W-1:0] pat;
    for (int a = 0; a < 4096; a++) sram[a] = rec(A_BITS'(a));
    mem_dout = '0;
    rd_req = '0; rd_addr = '0; ld_req = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset: grants masked even with requests up, strobes and valid low.
    rst_ni = 1'b0;
    tick();
    rd_req = 4'b1111; ld_req = 1'b1;
    tick();
    #1;
    check_eq("rst_rd_gnt", REC_W'(rd_gnt), '0);
    check_eq("rst_ld_gnt", REC_W'(ld_gnt), '0);
    check_eq("rst_rd_en", REC_W'(mem_rd_en), '0);
    check_eq("rst_wr_en", REC_W'(mem_wr_en), '0);
    check_eq("rst_valid", REC_W'(rd_valid), '0);
    check_eq("rst_rd_addr", REC_W'(mem_rd_addr), '0);
    rd_req = '0; ld_req = 1'b0;
    tick();
    rst_ni = 1'b1;

    // Single read from streamer 2 at 0x03A.
    rd_req = 4'b0100; set_addr(2, 12'h03A);
    #1 check_eq("single_gnt", REC_W'(rd_gnt), REC_W'(4'b0100));
    tick();
    rd_req = '0;
    #1;
    check_eq("single_rd_en", REC_W'(mem_rd_en), 1);
    check_eq("single_rd_addr", REC_W'(mem_rd_addr), REC_W'(12'h03A));
    check_eq("single_valid_early", REC_W'(rd_valid), '0);
    tick();
    check_eq("single_valid", REC_W'(rd_valid), REC_W'(4'b0100));
    check_eq("single_data", rd_data, rec(12'h03A));

    // Round-robin from reset: grants 0..3 twice, valids trail by 2 with no bubbles.
    do_reset();
    for (int k = 0; k < 4; k++) set_addr(k, A_BITS'(12'h100 + k));
    for (int c = 0; c < 10; c++) begin
      rd_req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      check_eq($sformatf("rr_gnt%0d", c), REC_W'(rd_gnt),
               (c < 8) ? REC_W'(4'b0001 << (c % 4)) : '0);
      if (c >= 2) begin
        check_eq($sformatf("rr_valid%0d", c), REC_W'(rd_valid), REC_W'(4'b0001 << ((c - 2) % 4)));
        check_eq($sformatf("rr_data%0d", c), rd_data, rec(A_BITS'(12'h100 + (c - 2) % 4)));
      end else begin
        check_eq($sformatf("rr_valid%0d", c), REC_W'(rd_valid), '0);
      end
      tick();
    end
    rd_req = '0;

    // Starvation guard: 8 loader grants, one read, loader again.
    do_reset();
    ld_req = 1'b1; ld_addr = 12'h200; ld_data = rec(12'h7FF);
    rd_req = 4'b0001; set_addr(0, 12'h300);
    for (int c = 0; c < 10; c++) begin
      #1;
      check_eq($sformatf("burst_ld%0d", c), REC_W'(ld_gnt), REC_W'(c != 8));
      check_eq($sformatf("burst_rd%0d", c), REC_W'(rd_gnt), (c == 8) ? REC_W'(4'b0001) : '0);
      if (c >= 1) check_eq($sformatf("burst_wr_en%0d", c), REC_W'(mem_wr_en), REC_W'(c != 9));
      tick();
    end
    rd_req = '0;
    for (int c = 0; c < 12; c++) begin
      #1 check_eq($sformatf("ld_only%0d", c), REC_W'(ld_gnt), 1);
      tick();
    end

    // Write-then-read to 0x010 via streamer 1.
    for (int w = 0; w < TRI_WORDS; w++) pat[w*D_BITS +: D_BITS] = 32'hA5A5_0000 + 32'(w);
    ld_addr = 12'h010; ld_data = pat;
    #1 check_eq("wr_ld_gnt", REC_W'(ld_gnt), 1);
    tick();
    ld_req = 1'b0; rd_req = 4'b0010; set_addr(1, 12'h010);
    #1;
    check_eq("wr_rd_gnt", REC_W'(rd_gnt), REC_W'(4'b0010));
    check_eq("wr_wr_en", REC_W'(mem_wr_en), 1);
    check_eq("wr_addr", REC_W'(mem_wr_addr), REC_W'(12'h010));
    check_eq("wr_din", mem_din, pat);
    tick();
    rd_req = '0;
    #1 check_eq("wr_rd_en", REC_W'(mem_rd_en), 1);
    tick();
    check_eq("wr_valid", REC_W'(rd_valid), REC_W'(4'b0010));
    check_eq("wr_data", rd_data, pat);

    // Reset right after a read grant kills its valid and rewinds the pointer.
    for (int k = 0; k < 4; k++) set_addr(k, A_BITS'(12'h100 + k));
    rd_req = 4'b1111;
    #1 check_eq("mid_gnt", REC_W'(rd_gnt), REC_W'(4'b0100));
    tick();
    rst_ni = 1'b0;
    #1 check_eq("mid_rst_gnt", REC_W'(rd_gnt), '0);
    tick();
    rst_ni = 1'b1;
    #1;
    check_eq("mid_rd_en", REC_W'(mem_rd_en), '0);
    check_eq("mid_wr_en", REC_W'(mem_wr_en), '0);
    check_eq("mid_valid", REC_W'(rd_valid), '0);
    check_eq("mid_gnt0", REC_W'(rd_gnt), REC_W'(4'b0001));
    tick();
    rd_req = '0;
    #1;
    check_eq("mid_valid2", REC_W'(rd_valid), '0);
    check_eq("mid_rd_addr", REC_W'(mem_rd_addr), REC_W'(12'h100));
    tick();
    check_eq("mid_valid3", REC_W'(rd_valid), REC_W'(4'b0001));
    check_eq("mid_data3", rd_data, rec(12'h100));

    // Wrap from 3 to 0, then an idle cycle holds the pointer.
    rd_req = 4'b1000; set_addr(3, 12'h3F0); set_addr(0, 12'h005);
    #1 check_eq("wrap_gnt3", REC_W'(rd_gnt), REC_W'(4'b1000));
    tick();
    rd_req = '0;
    #1 check_eq("wrap_idle", REC_W'(rd_gnt), '0);
    tick();
    rd_req = 4'b1001;
    #1;
    check_eq("wrap_gnt0", REC_W'(rd_gnt), REC_W'(4'b0001));
    check_eq("wrap_valid3", REC_W'(rd_valid), REC_W'(4'b1000));
    check_eq("wrap_data3", rd_data, rec(12'h3F0));
    tick();
    rd_req = '0;
    tick();
    rd_req = 4'b1001;
    #1 check_eq("hold_gnt3", REC_W'(rd_gnt), REC_W'(4'b1000));
    tick();
    rd_req = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tri_mem_arbiter.md
Name: tri_mem_arbiter

Overview:
- Shares the single triangle SRAM between N_REQ ray streamers (read clients) and one scene loader (write client).
- Each cycle it issues at most one SRAM access:
  - loader writes have priority, bounded by a starvation guard;
  - reads are granted round-robin.
- Read data is tagged back to the granted streamer as a one-hot rvalid.
- Sits between the STREAMER instances and the triangle SRAM.

Parameters:
- N_REQ, 4, number of streamer read clients (2..8)
- A_BITS, 12, triangle SRAM address width
- D_BITS, 32, fixed-point word width
- TRI_WORDS, 12, words per triangle record (data bus = TRI_WORDS*D_BITS)
- MEM_LAT, 1, SRAM cycles from sampled mem_rd_en to valid mem_dout (1..4)
- LD_BURST, 8, max consecutive loader grants while any read is pending

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- rd_req  in  N_REQ  per-streamer read request; held with address until granted
- rd_addr  in  N_REQ*A_BITS  per-streamer address, slice k = [A_BITS*k +: A_BITS]
- rd_gnt  out  N_REQ  one-hot, combinational; request accepted on this edge
- rd_valid  out  N_REQ  one-hot; rd_data belongs to that streamer this cycle
- rd_data  out  TRI_WORDS*D_BITS  triangle record (pass-through of mem_dout)
- ld_req  in  1  loader write request
- ld_addr  in  A_BITS  write address
- ld_data  in  TRI_WORDS*D_BITS  write record
- ld_gnt  out  1  combinational; write accepted on this edge
- mem_rd_en  out  1  registered SRAM read strobe
- mem_rd_addr  out  A_BITS  registered SRAM read address
- mem_wr_en  out  1  registered SRAM write strobe
- mem_wr_addr  out  A_BITS  registered write address
- mem_din  out  TRI_WORDS*D_BITS  registered write data
- mem_dout  in  TRI_WORDS*D_BITS  SRAM read data

Behaviour:

Reset (reset==0 at posedge):
- rr_ptr=0, ld_streak=0, tag pipeline cleared.
- mem_rd_en=0, mem_wr_en=0; mem_rd_addr, mem_wr_addr, mem_din = 0.
- rd_valid=0.
- rd_gnt and ld_gnt are forced 0 while reset is low.
- A reset mid-read discards all in-flight tags, so no rd_valid is produced for reads issued before reset.

Arbitration (combinational, per cycle):
- Writes: if ld_req, and not (ld_streak==LD_BURST and |rd_req), then ld_gnt=1 and rd_gnt=0.
- Reads otherwise: rd_gnt = first k with rd_req[k], searching from rr_ptr upward and wrapping modulo N_REQ.
- At most one of ld_gnt and rd_gnt bits is set; read and write never share a cycle.

State update on the edge:
- Read grant k: rr_ptr <= (k+1) mod N_REQ; ld_streak <= 0.
- Loader grant: ld_streak <= ld_streak+1, saturating at LD_BURST.
- No grant: rr_ptr and ld_streak hold.
- ld_streak also clears to 0 on any cycle with no ld_req.

SRAM strobes:
- On a read grant: mem_rd_en<=1, mem_rd_addr<=addr slice k.
- On a loader grant: mem_wr_en<=1, mem_wr_addr<=ld_addr, mem_din<=ld_data.
- Strobes are single-cycle pulses, 0 otherwise; addresses and data hold their last value.

Read return:
- The one-hot grant enters a tag shift register of depth 1+MEM_LAT.
- rd_valid = tag output, exactly 1+MEM_LAT cycles after the grant cycle (grant in cycle T -> rd_valid in T+2 for MEM_LAT=1).
- rd_data = mem_dout, driven every cycle; meaningful only when |rd_valid.
- Back-to-back grants produce back-to-back rd_valid, one read per cycle sustained.

Client rules:
- A client must keep rd_req and its address stable until rd_gnt is seen.
- It may deassert rd_req on the cycle after the grant, or keep it high for another read.
- A requester dropping rd_req without a grant is legal; nothing is issued for it.

Hazards:
- A read issued after a write grant to the same address returns the new data (SRAM write-first order is guaranteed by the registered, serialized strobes).
- No other hazard handling.

Test Plan:
- Single read: rd_req=4'b0100, rd_addr[2]=12'h03A in cycle 5 -> rd_gnt=4'b0100 in cycle 5; mem_rd_en=1, mem_rd_addr=12'h03A in cycle 6; rd_valid=4'b0100 with the record at 0x03A in cycle 7.
- Round-robin: all four rd_req held high for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; rd_valid follows 2 cycles later, one per cycle, no bubbles.
- Loader priority and starvation guard, LD_BURST=8:
  - ld_req held high with rd_req=4'b0001 -> 8 consecutive ld_gnt, then rd_gnt[0] for one cycle, then ld_gnt again.
  - With rd_req=0 the loader is granted every cycle.
- Write-then-read: loader writes pattern 0xA5A5_0000+i to address 0x010, then streamer 1 reads 0x010 -> rd_valid=4'b0010 with the written record.
- Reset mid-operation: reset low for 1 cycle immediately after a read grant -> no rd_valid for that read; rr_ptr=0, so with all requests high the next grant goes to streamer 0; mem_rd_en=0 and mem_wr_en=0 during reset.
- Wrap and hold: only rd_req[3] high -> grant 3 and rr_ptr=0; then rd_req=4'b1001 -> grant 0 next. An idle cycle between requests leaves rr_ptr unchanged.
